board_core_resp: RTL and testbench

//  Responder end of the memory-game board handshake: owns the 16-card board (symbol + visual state per slot),

---
 rtl/board_pkg.sv | 41 ++++
 rtl/board_core_resp_anim_timer.sv | 35 +++
 rtl/board_core_resp.sv | 252 +++++++++++++++++++++++++
 tb/tb_board_core_resp.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/board_pkg.sv
// Shared types and helpers for the memory-game board responder.
// Card states, engine op codes, default geometry, legality helpers.
package board_pkg;

   localparam int NUM_CARDS_DEF = 16;
   localparam int SYM_W_DEF     = 3;

   typedef enum logic [1:0] {
      C_HIDDEN  = 2'd0,
      C_FACE_UP = 2'd1,
      C_REMOVED = 2'd2
   } card_state_t;

   typedef enum logic [1:0] {
      OP_FLIP   = 2'd0,
      OP_UNFLIP = 2'd1,
      OP_REMOVE = 2'd2
   } op_t;

   function automatic logic op_legal(op_t op, card_state_t st);
      logic ok;
      case (op)
         OP_FLIP:   ok = (st == C_HIDDEN);
         OP_UNFLIP: ok = (st == C_FACE_UP);
         OP_REMOVE: ok = (st == C_FACE_UP);
         default:   ok = 1'b0;
      endcase
      return ok;
   endfunction

   function automatic card_state_t op_result(op_t op);
      card_state_t r;
      case (op)
         OP_FLIP:   r = C_FACE_UP;
         OP_UNFLIP: r = C_HIDDEN;
         default:   r = C_REMOVED;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/board_core_resp_anim_timer.sv
// anim_timer: clear-to-zero up-counter that stops at CYCLES.
// Ports: clk, reset_n, clr_i (force 0), en_i (count), tc_o (count==CYCLES).
module anim_timer #(
   parameter int CYCLES = 4
) (
   input  logic clk,
   input  logic reset_n,
   input  logic clr_i,
   input  logic en_i,
   output logic tc_o
);

   localparam int W = (CYCLES > 0) ? $clog2(CYCLES + 1) : 1;
   localparam logic [W-1:0] TERM = W'(CYCLES);

   logic [W-1:0] cnt_q, cnt_d;

   assign tc_o = (cnt_q == TERM);

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i)
         cnt_d = '0;
      else if (en_i && !tc_o)
         cnt_d = cnt_q + W'(1);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

endmodule

// File: rtl/board_core_resp.sv
// board_core_resp: board owner for the memory game; services flip/unflip/remove
// requests with delayed 1-cycle acks, tracks removed cards and sticky errors.
// Ports: deck_load/deck_sym load a board; req_*/act_idx issue ops; *_ack done;
// sel_idx/can_flip_sel cursor query; busy; all_pairs_done; card_state/card_sym
// render buses; err_sticky. BOARD_PAIR_CHECK_EN adds pair_start/idx_a/idx_b ->
// pair_done/pair_match compare responder.
module board_core_resp
   import board_pkg::*;
#(
   parameter int NUM_CARDS   = NUM_CARDS_DEF,
   parameter int SYM_W       = SYM_W_DEF,
   parameter int ANIM_CYCLES = 12_500_000
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic                       deck_load,
   input  logic [NUM_CARDS*SYM_W-1:0] deck_sym,
   input  logic                       req_flip,
   input  logic                       req_unflip,
   input  logic                       req_remove_pair,
   input  logic [3:0]                 act_idx,
   input  logic [3:0]                 sel_idx,
   output logic                       flip_ack,
   output logic                       unflip_ack,
   output logic                       remove_ack,
   output logic                       can_flip_sel,
   output logic                       busy,
   output logic                       all_pairs_done,
   output logic [NUM_CARDS*2-1:0]     card_state,
   output logic [NUM_CARDS*SYM_W-1:0] card_sym,
   output logic                       err_sticky
`ifdef BOARD_PAIR_CHECK_EN
   ,
   input  logic                       pair_start,
   input  logic [3:0]                 idx_a,
   input  logic [3:0]                 idx_b,
   output logic                       pair_done,
   output logic                       pair_match
`endif
);

   localparam logic [1:0] B_IDLE = 2'd0;
   localparam logic [1:0] B_ANIM = 2'd1;
   localparam logic [1:0] B_ACK  = 2'd2;
   localparam logic [4:0] NUM5   = 5'(NUM_CARDS);

   logic [1:0]                 eng_q, eng_d;
   op_t                        op_q, op_d;
   logic [3:0]                 act_q, act_d;
   card_state_t                st_q [NUM_CARDS];
   card_state_t                st_d [NUM_CARDS];
   logic [NUM_CARDS*SYM_W-1:0] sym_q, sym_d;
   logic [4:0]                 cnt_q, cnt_d;
   logic                       err_q, err_d;
   logic                       done_q;

   logic        tc;
   logic        any_req;
   logic [1:0]  nreq;
   card_state_t act_st;
   card_state_t sel_st;
   logic        act_ok;

   anim_timer #(
      .CYCLES (ANIM_CYCLES)
   ) u_timer (
      .clk     (clk),
      .reset_n (reset_n),
      .clr_i   (eng_q == B_IDLE),
      .en_i    (eng_q == B_ANIM),
      .tc_o    (tc)
   );

   assign any_req = req_flip | req_unflip | req_remove_pair;
   assign nreq    = {1'b0, req_flip} + {1'b0, req_unflip}
                  + {1'b0, req_remove_pair};

   always_comb begin
      act_st = C_HIDDEN;
      sel_st = C_REMOVED;
      for (int i = 0; i < NUM_CARDS; i++) begin
         if (act_q == 4'(i))
            act_st = st_q[i];
         if (sel_idx == 4'(i))
            sel_st = st_q[i];
      end
   end

   // Out-of-range slots are never legal but still run the full delay.
   assign act_ok = ({1'b0, act_q} < NUM5) && op_legal(op_q, act_st);

   always_comb begin
      eng_d = eng_q;
      op_d  = op_q;
      act_d = act_q;
      st_d  = st_q;
      sym_d = sym_q;
      cnt_d = cnt_q;
      err_d = err_q;
      unique case (eng_q)
         B_IDLE: begin
            if (deck_load) begin
               sym_d = deck_sym;
               for (int i = 0; i < NUM_CARDS; i++)
                  st_d[i] = C_HIDDEN;
               cnt_d = '0;
               err_d = 1'b0;
            end
            if (any_req) begin
               eng_d = B_ANIM;
               act_d = act_idx;
               priority case (1'b1)
                  req_remove_pair: op_d = OP_REMOVE;
                  req_unflip:      op_d = OP_UNFLIP;
                  default:         op_d = OP_FLIP;
               endcase
               if (nreq > 2'd1)
                  err_d = 1'b1;
            end
         end
         B_ANIM: begin
            if (tc) begin
               eng_d = B_ACK;
               // Slot update lands on the edge the ack rises.
               if (act_ok) begin
                  for (int i = 0; i < NUM_CARDS; i++)
                     if (act_q == 4'(i))
                        st_d[i] = op_result(op_q);
                  if (op_q == OP_REMOVE && cnt_q != NUM5)
                     cnt_d = cnt_q + 5'd1;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         B_ACK:   eng_d = B_IDLE;
         default: eng_d = B_IDLE;
      endcase
      if (eng_q != B_IDLE && (any_req || deck_load))
         err_d = 1'b1;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         eng_q  <= B_IDLE;
         op_q   <= OP_FLIP;
         act_q  <= '0;
         sym_q  <= '0;
         cnt_q  <= '0;
         err_q  <= 1'b0;
         done_q <= 1'b0;
         for (int i = 0; i < NUM_CARDS; i++)
            st_q[i] <= C_HIDDEN;
      end else begin
         eng_q  <= eng_d;
         op_q   <= op_d;
         act_q  <= act_d;
         sym_q  <= sym_d;
         cnt_q  <= cnt_d;
         err_q  <= err_d;
         done_q <= (cnt_d == NUM5);
         st_q   <= st_d;
      end
   end

   always_comb begin
      card_state = '0;
      for (int i = 0; i < NUM_CARDS; i++)
         card_state[2*i +: 2] = st_q[i];
   end

   assign card_sym       = sym_q;
   assign busy           = (eng_q == B_ANIM);
   assign flip_ack       = (eng_q == B_ACK) && (op_q == OP_FLIP);
   assign unflip_ack     = (eng_q == B_ACK) && (op_q == OP_UNFLIP);
   assign remove_ack     = (eng_q == B_ACK) && (op_q == OP_REMOVE);
   assign all_pairs_done = done_q;
   assign err_sticky     = err_q;
   assign can_flip_sel   = (eng_q == B_IDLE)
                         && ({1'b0, sel_idx} < NUM5)
                         && (sel_st == C_HIDDEN);

`ifdef BOARD_PAIR_CHECK_EN
   localparam logic [1:0] P_IDLE = 2'd0;
   localparam logic [1:0] P_DONE = 2'd1;
   localparam logic [1:0] P_COOL = 2'd2;

   logic [1:0]       pst_q, pst_d;
   logic             pdone_q, pdone_d;
   logic             pmatch_q, pmatch_d;
   logic [SYM_W-1:0] sa, sb;
   card_state_t      sta, stb;
   logic             match_now;

   always_comb begin
      sa  = '0;
      sb  = '0;
      sta = C_HIDDEN;
      stb = C_HIDDEN;
      for (int i = 0; i < NUM_CARDS; i++) begin
         if (idx_a == 4'(i)) begin
            sa  = sym_q[i*SYM_W +: SYM_W];
            sta = st_q[i];
         end
         if (idx_b == 4'(i)) begin
            sb  = sym_q[i*SYM_W +: SYM_W];
            stb = st_q[i];
         end
      end
   end

   assign match_now = (sa == sb) && (idx_a != idx_b)
                    && ({1'b0, idx_a} < NUM5)
                    && ({1'b0, idx_b} < NUM5)
                    && (sta == C_FACE_UP) && (stb == C_FACE_UP);

   // P_COOL swallows the level-held pair_start after the done cycle.
   always_comb begin
      pst_d    = pst_q;
      pdone_d  = 1'b0;
      pmatch_d = 1'b0;
      unique case (pst_q)
         P_IDLE: begin
            if (pair_start) begin
               pst_d    = P_DONE;
               pdone_d  = 1'b1;
               pmatch_d = match_now;
            end
         end
         P_DONE:  pst_d = P_COOL;
         P_COOL:  pst_d = P_IDLE;
         default: pst_d = P_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pst_q    <= P_IDLE;
         pdone_q  <= 1'b0;
         pmatch_q <= 1'b0;
      end else begin
         pst_q    <= pst_d;
         pdone_q  <= pdone_d;
         pmatch_q <= pmatch_d;
      end
   end

   assign pair_done  = pdone_q;
   assign pair_match = pmatch_q;
`endif

endmodule

// File: tb/tb_board_core_resp.sv
// Bench for board_core_resp: cycle-indexed behavioural model plus
// directed scenarios and random traffic, ANIM_CYCLES=4.
module tb_board_core_resp;

   localparam int N    = 16;
   localparam int SW   = 3;
   localparam int ANIM = 4;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          deck_load = 1'b0;
   logic [N*SW-1:0] deck_sym = '0;
   logic          req_flip = 1'b0;
   logic          req_unflip = 1'b0;
   logic          req_remove_pair = 1'b0;
   logic [3:0]    act_idx = '0;
   logic [3:0]    sel_idx = '0;
   logic          flip_ack, unflip_ack, remove_ack;
   logic          can_flip_sel, busy, all_pairs_done;
   logic [N*2-1:0]  card_state;
   logic [N*SW-1:0] card_sym;
   logic          err_sticky;
`ifdef BOARD_PAIR_CHECK_EN
   logic          pair_start = 1'b0;
   logic [3:0]    idx_a = '0;
   logic [3:0]    idx_b = '0;
   logic          pair_done, pair_match;
`endif

   int total = 0;
   int bad   = 0;
   bit chk_on = 1'b0;

   board_core_resp #(
      .NUM_CARDS   (N),
      .SYM_W       (SW),
      .ANIM_CYCLES (ANIM)
   ) dut (
      .clk             (clk),
      .reset_n         (reset_n),
      .deck_load       (deck_load),
      .deck_sym        (deck_sym),
      .req_flip        (req_flip),
      .req_unflip      (req_unflip),
      .req_remove_pair (req_remove_pair),
      .act_idx         (act_idx),
      .sel_idx         (sel_idx),
      .flip_ack        (flip_ack),
      .unflip_ack      (unflip_ack),
      .remove_ack      (remove_ack),
      .can_flip_sel    (can_flip_sel),
      .busy            (busy),
      .all_pairs_done  (all_pairs_done),
      .card_state      (card_state),
      .card_sym        (card_sym),
      .err_sticky      (err_sticky)
`ifdef BOARD_PAIR_CHECK_EN
      ,
      .pair_start      (pair_start),
      .idx_a           (idx_a),
      .idx_b           (idx_b),
      .pair_done       (pair_done),
      .pair_match      (pair_match)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [63:0] act,
                        input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   // e counts clock edges; an op accepted at edge ta completes at
   // edge ta+ANIM+1 (ack visible for that one cycle).
   int e = 0;
   bit pend = 1'b0;
   int ta = 0;
   int mop = 0;
   int midx = 0;
   int mst [N];
   int msym [N];
   int mcnt = 0;
   bit merr = 1'b0;

   task automatic model_reset();
      e = 0; pend = 0; mcnt = 0; merr = 0;
      for (int i = 0; i < N; i++) begin
         mst[i] = 0;
         msym[i] = 0;
      end
   endtask

   initial begin
      model_reset();
      forever begin
         @(posedge clk or negedge reset_n);
         if (!reset_n) begin
            model_reset();
         end else begin
            bit idle_now;
            int nr;
            e++;
            idle_now = !pend;
            if (pend && e == ta + ANIM + 1) begin
               bit legal;
               legal = (mop == 0) ? (mst[midx] == 0) : (mst[midx] == 1);
               if (legal) begin
                  mst[midx] = (mop == 0) ? 1 : (mop == 1) ? 0 : 2;
                  if (mop == 2 && mcnt < N) mcnt++;
               end else merr = 1;
            end
            if (pend && e == ta + ANIM + 2) pend = 0;
            nr = int'(req_flip) + int'(req_unflip) + int'(req_remove_pair);
            if (idle_now) begin
               if (deck_load) begin
                  for (int i = 0; i < N; i++) begin
                     mst[i] = 0;
                     msym[i] = int'(deck_sym[i*SW +: SW]);
                  end
                  mcnt = 0;
                  merr = 0;
               end
               if (nr > 0) begin
                  pend = 1; ta = e;
                  mop = req_remove_pair ? 2 : req_unflip ? 1 : 0;
                  midx = int'(act_idx);
                  if (nr > 1) merr = 1;
               end
            end else if (nr > 0 || deck_load) merr = 1;
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   logic [N*2-1:0]  x_st;
   logic [N*SW-1:0] x_sym;
   bit x_busy, x_ack, x_can;

   initial forever begin
      @(negedge clk);
      if (chk_on) begin
         for (int i = 0; i < N; i++) begin
            x_st[2*i +: 2]   = 2'(mst[i]);
            x_sym[SW*i +: SW] = SW'(msym[i]);
         end
         x_busy = pend && (e <= ta + ANIM);
         x_ack  = pend && (e == ta + ANIM + 1);
         x_can  = !pend && (mst[sel_idx] == 0);
         check("card_state", 64'(card_state), 64'(x_st));
         check("card_sym", 64'(card_sym), 64'(x_sym));
         check("busy", 64'(busy), 64'(x_busy));
         check("flip_ack", 64'(flip_ack), 64'(x_ack && mop == 0));
         check("unflip_ack", 64'(unflip_ack), 64'(x_ack && mop == 1));
         check("remove_ack", 64'(remove_ack), 64'(x_ack && mop == 2));
         check("can_flip_sel", 64'(can_flip_sel), 64'(x_can));
         check("err_sticky", 64'(err_sticky), 64'(merr));
         check("all_pairs_done", 64'(all_pairs_done), 64'(mcnt == N));
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic deck(input logic [N*SW-1:0] v);
      @(negedge clk); #1;
      deck_load = 1'b1;
      deck_sym = v;
      @(negedge clk); #1;
      deck_load = 1'b0;
   endtask

   task automatic do_req(input logic f, input logic u, input logic r,
                         input logic [3:0] idx, output int edges,
                         output logic [2:0] acks,
                         output logic [N*2-1:0] st, output logic err,
                         output logic done);
      logic [2:0] a;
      edges = 0; acks = '0; st = '0; err = 1'b0; done = 1'b0;
      @(negedge clk); #1;
      req_flip = f; req_unflip = u; req_remove_pair = r; act_idx = idx;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         a = {remove_ack, unflip_ack, flip_ack};
         if (k == 1) begin
            st = card_state;
            #1;
            req_flip = 0; req_unflip = 0; req_remove_pair = 0;
         end
         if (a != 3'b000) begin
            edges = k; acks = a;
            st = card_state; err = err_sticky; done = all_pairs_done;
            break;
         end
      end
      if (edges == 0) check("ack_timeout", 64'(0), 64'(1));
      @(negedge clk);
   endtask

   logic [N*SW-1:0] pairs_deck;
   int ed;
   logic [2:0] ak;
   logic [N*2-1:0] sn;
   logic er, dn;
   int nack;

   initial begin
      for (int i = 0; i < N; i++) pairs_deck[i*SW +: SW] = SW'(i / 2);

      cyc(3);
      chk_on = 1'b1;
      cyc(1);
      check("rst_state", 64'(card_state), 64'(0));
      check("rst_busy", 64'(busy), 64'(0));
      check("rst_done", 64'(all_pairs_done), 64'(0));
      #1 reset_n = 1'b1;
      cyc(2);

      deck(pairs_deck);
      check("deck_sym", 64'(card_sym), 64'(pairs_deck));

      do_req(1, 0, 0, 4'd3, ed, ak, sn, er, dn);
      check("flip3_lat", 64'(ed), 64'(6));
      check("flip3_ack", 64'(ak), 64'(3'b001));
      check("flip3_st", 64'(sn[7:6]), 64'(1));
      check("flip3_err", 64'(er), 64'(0));
      check("ack_1cyc", 64'(flip_ack), 64'(0));

      do_req(1, 0, 0, 4'd3, ed, ak, sn, er, dn);
      check("reflip_lat", 64'(ed), 64'(6));
      check("reflip_st", 64'(sn[7:6]), 64'(1));
      check("reflip_err", 64'(er), 64'(1));

      deck(pairs_deck);
      check("reload_err", 64'(err_sticky), 64'(0));
      check("reload_st", 64'(card_state), 64'(0));

      for (int p = 0; p < N / 2; p++) begin
         do_req(1, 0, 0, 4'(2*p), ed, ak, sn, er, dn);
         do_req(1, 0, 0, 4'(2*p+1), ed, ak, sn, er, dn);
         do_req(0, 0, 1, 4'(2*p), ed, ak, sn, er, dn);
         if (p == 0) check("rm0_ack", 64'(ak), 64'(3'b100));
         do_req(0, 0, 1, 4'(2*p+1), ed, ak, sn, er, dn);
         if (p == 0) begin
            check("rm01_st", 64'(sn[3:0]), 64'(4'b1010));
            check("rm01_done", 64'(dn), 64'(0));
         end
      end
      check("all_done", 64'(dn), 64'(1));
      check("all_done_err", 64'(er), 64'(0));

      deck(pairs_deck);
      do_req(1, 0, 0, 4'd5, ed, ak, sn, er, dn);
      do_req(1, 1, 0, 4'd5, ed, ak, sn, er, dn);
      check("dual_ack", 64'(ak), 64'(3'b010));
      check("dual_st", 64'(sn[11:10]), 64'(0));
      check("dual_err", 64'(er), 64'(1));

      deck(pairs_deck);
      do_req(1, 0, 0, 4'd0, ed, ak, sn, er, dn);
      do_req(0, 0, 1, 4'd0, ed, ak, sn, er, dn);
      #1 sel_idx = 4'd2;
      cyc(1);
      check("sel2_idle", 64'(can_flip_sel), 64'(1));
      #1 req_flip = 1'b1; act_idx = 4'd4;
      cyc(1);
      #1 req_flip = 1'b0;
      cyc(1);
      check("sel2_busy", 64'(can_flip_sel), 64'(0));
      cyc(8);
      #1 sel_idx = 4'd0;
      cyc(1);
      check("sel0_rm", 64'(can_flip_sel), 64'(0));

      #1 req_flip = 1'b1; act_idx = 4'd7;
      cyc(1);
      #1 req_flip = 1'b0;
      cyc(1);
      check("mid_busy", 64'(busy), 64'(1));
      #1 reset_n = 1'b0;
      nack = 0;
      for (int k = 0; k < 3; k++) begin
         cyc(1);
         nack += int'(flip_ack);
      end
      #1 reset_n = 1'b1;
      for (int k = 0; k < 10; k++) begin
         cyc(1);
         nack += int'(flip_ack | unflip_ack | remove_ack);
      end
      check("rst_noack", 64'(nack), 64'(0));
      check("rst_st", 64'(card_state), 64'(0));

      deck({$urandom, $urandom});
      for (int k = 0; k < 600; k++) begin
         int r;
         @(negedge clk); #1;
         r = $urandom_range(0, 99);
         req_flip        = (r < 10);
         req_unflip      = (r >= 8) && (r < 14);
         req_remove_pair = (r >= 14) && (r < 22);
         deck_load       = (r == 99);
         deck_sym        = {$urandom, $urandom};
         act_idx         = 4'($urandom_range(0, N - 1));
         sel_idx         = 4'($urandom_range(0, N - 1));
      end
      @(negedge clk); #1;
      req_flip = 0; req_unflip = 0; req_remove_pair = 0; deck_load = 0;
      cyc(10);

`ifdef BOARD_PAIR_CHECK_EN
      deck(pairs_deck);
      do_req(1, 0, 0, 4'd6, ed, ak, sn, er, dn);
      do_req(1, 0, 0, 4'd7, ed, ak, sn, er, dn);
      for (int t = 0; t < 2; t++) begin
         int nd;
         logic m;
         nd = 0; m = 1'b0;
         #1 idx_a = 4'd6; idx_b = (t == 0) ? 4'd7 : 4'd6;
         pair_start = 1'b1;
         for (int k = 0; k < 6; k++) begin
            cyc(1);
            if (pair_done) begin nd++; m = pair_match; end
            if (k == 2) #1 pair_start = 1'b0;
         end
         check("pair_ndone", 64'(nd), 64'(1));
         check("pair_match", 64'(m), 64'(t == 0));
      end
`endif

      chk_on = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
